// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, FSM states and byte-lane helper for data_mem_ctrl
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half of a read word and sign/zero-extends it
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    data = size == SZ_BYTE ? {{24{sign_ext & b[7]}}, b} :
           size == SZ_HALF ? {{16{sign_ext & h[15]}}, h} : word;
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte/half/word data memory with post-reset clear sweep and optional output register.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses with an err pulse instead of forcing the offset down.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter int          OUT_REG  = 0,
  parameter logic [31:0] INIT_VAL = 32'h0
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W+1:0] addr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              valid,
  output logic              busy,
  output logic              err
);
  logic [31:0] mem [0:2**ADDR_W-1];
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, idx, wa;
  logic [1:0] off, rd_off, rd_size;
  logic mis, acc, st, ld, rd_sx, v1, e1;
  logic [3:0] wm;
  logic [31:0] wd, rd, al;
  always_comb begin
    idx = addr[ADDR_W+1:2];
    off = size == SZ_BYTE ? addr[1:0] : size == SZ_HALF ? {addr[1], 1'b0} : 2'b00;
`ifdef MEM_ALIGN_CHECK_EN
    mis = off != addr[1:0];
`else
    mis = 1'b0;
`endif
    acc = en && state == ST_IDLE;
    st = acc && we && !mis;
    ld = acc && !we && !mis;
    state_n = state == ST_INIT && &cnt ? ST_IDLE : state;
    wa = state == ST_INIT ? cnt : idx;
    wm = state == ST_INIT ? 4'b1111 : st ? lane_mask(size, off) : 4'b0000;
    wd = state == ST_INIT ? INIT_VAL : size == SZ_BYTE ? {4{din[7:0]}} :
         size == SZ_HALF ? {2{din[15:0]}} : din;
  end
  assign busy = state == ST_INIT;
  // store data is replicated across lanes so the byte enables alone place it
  always_ff @(posedge clka)
    for (int i = 0; i < 4; i++)
      if (wm[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) begin
      state <= ST_INIT;
      cnt <= '0;
      rd <= '0;
      rd_off <= '0;
      rd_size <= '0;
      rd_sx <= 1'b0;
      v1 <= 1'b0;
      e1 <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
      v1 <= ld;
      e1 <= acc && mis;
      if (ld) begin
        rd <= mem[idx];
        rd_off <= off;
        rd_size <= size;
        rd_sx <= sign_ext;
      end
    end
  mem_load_align u_align (.word(rd), .off(rd_off), .size(rd_size), .sign_ext(rd_sx), .data(al));
  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clka or negedge rst_n)
        if (!rst_n) begin
          dout <= '0;
          valid <= 1'b0;
          err <= 1'b0;
        end else begin
          valid <= v1;
          err <= e1;
          if (v1) dout <= al;
        end
    end else begin : g_direct
      assign dout = al;
      assign valid = v1;
      assign err = e1;
    end
  endgenerate
endmodule
